lock_sequencer: RTL and testbench



---
 rtl/lock_pkg.sv | 38 +++
 rtl/digit_collector.sv | 40 ++++
 rtl/lock_sequencer.sv | 168 ++++++++++++++++
 tb/tb_lock_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared constants, gate-status encodings and the state type for the digital lock sequencer.
package lock_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned CODE_W     = DIGIT_W * NUM_DIGITS;
    localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned FAIL_W     = 3;

    localparam logic [2:0] GS_CLOSED  = 3'd0;
    localparam logic [2:0] GS_OPEN    = 3'd1;
    localparam logic [2:0] GS_IDLE    = 3'd2;
    localparam logic [2:0] GS_ENTER   = 3'd3;
    localparam logic [2:0] GS_CHANGE  = 3'd4;
    localparam logic [2:0] GS_REENTER = 3'd5;
    localparam logic [2:0] GS_SCROLL  = 3'd6;

    // State encoding equals the gate status, so the state register drives gate_status directly.
    typedef enum logic [2:0] {
        StClosed  = GS_CLOSED,
        StOpen    = GS_OPEN,
        StIdle    = GS_IDLE,
        StEnter   = GS_ENTER,
        StChange  = GS_CHANGE,
        StReenter = GS_REENTER,
        StScroll  = GS_SCROLL
    } lockState_t;

    function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic isDigit(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(9);
    endfunction

endpackage

// File: rtl/digit_collector.sv
// Shift-in buffer for keypad digits: first digit lands in the top nibble, done flags a full code.
module digit_collector
    import lock_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic [DIGIT_W-1:0]  digit,
    output logic [CODE_W-1:0]   digits,
    output logic [IDX_W-1:0]    currentIndex,
    output logic                done
);

    logic [CNT_W-1:0] cnt;

    assign done = (cnt == CNT_W'(NUM_DIGITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            digits       <= '0;
            currentIndex <= '0;
        end else if (clear) begin
            cnt          <= '0;
            digits       <= '0;
            currentIndex <= '0;
        end else if (load && !done) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cnt == CNT_W'(i)) begin
                    digits[CODE_W-1-DIGIT_W*i -: DIGIT_W] <= digit;
                end
            end
            // Index of the digit just written is the pre-increment count.
            currentIndex <= IDX_W'(cnt);
            cnt          <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lock_sequencer.sv
// Gate/lock FSM: code entry, open timeout, code change and lockout flows.
// Optional LOCK_LOCKOUT_EN adds the timed CLOSED state after the lockout scroll.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter logic [CODE_W-1:0] DEFAULT_CODE  = 16'h1234,
    parameter int unsigned       MAX_FAILS     = 3,
    parameter int unsigned       OPEN_TICKS    = 50_000_000,
    parameter int unsigned       LOCKOUT_TICKS = 100_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                digit_valid,
    input  logic [DIGIT_W-1:0]  digit,
    input  logic                enter_btn,
    input  logic                change_btn,
    input  logic                finished_scrolling,
    output logic [2:0]          gate_status,
    output logic [IDX_W-1:0]    current_index,
    output logic [CODE_W-1:0]   display_elements,
    output logic                unlock
);

    localparam int unsigned TimerRaw = $clog2(maxU(OPEN_TICKS, LOCKOUT_TICKS));
    localparam int unsigned TimerW   = (TimerRaw < 1) ? 1 : TimerRaw;
    localparam logic [TimerW-1:0] OpenLast = TimerW'(OPEN_TICKS - 1);
    localparam logic [FAIL_W-1:0] FailLast = FAIL_W'(MAX_FAILS - 1);

    lockState_t        state;
    logic [TimerW-1:0] openTimer;
    logic [FAIL_W-1:0] failCnt;
    logic [CODE_W-1:0] storedCode;
    logic [CODE_W-1:0] newCode;
`ifdef LOCK_LOCKOUT_EN
    localparam logic [TimerW-1:0] LockLast = TimerW'(LOCKOUT_TICKS - 1);
    logic [TimerW-1:0] lockTimer;
`endif

    logic              inEntry;
    logic              loadDigit;
    logic              clearBuf;
    logic              anyStrobe;
    logic              done;
    logic [CODE_W-1:0] digits;

    assign inEntry   = (state == StEnter) || (state == StChange) || (state == StReenter);
    assign anyStrobe = digit_valid || enter_btn || change_btn;
    // enter_btn is ignored in IDLE, so it only suppresses digits while an entry is in progress.
    assign loadDigit = digit_valid && isDigit(digit) &&
                       ((state == StIdle) || (inEntry && !enter_btn));
    assign clearBuf  = inEntry && (enter_btn || done);

    digit_collector u_collector (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clearBuf),
        .load         (loadDigit),
        .digit        (digit),
        .digits       (digits),
        .currentIndex (current_index),
        .done         (done)
    );

    assign gate_status      = state;
    assign display_elements = digits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            unlock     <= 1'b0;
            openTimer  <= '0;
            failCnt    <= '0;
            storedCode <= DEFAULT_CODE;
            newCode    <= '0;
`ifdef LOCK_LOCKOUT_EN
            lockTimer  <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (loadDigit) begin
                        state <= StEnter;
                    end
                end
                StEnter: begin
                    if (enter_btn) begin
                        state <= StIdle;
                    end else if (done) begin
                        if (digits == storedCode) begin
                            state     <= StOpen;
                            unlock    <= 1'b1;
                            openTimer <= '0;
                            failCnt   <= '0;
                        end else if (failCnt >= FailLast) begin
                            state   <= StScroll;
                            failCnt <= '0;
                        end else begin
                            state   <= StIdle;
                            failCnt <= failCnt + FAIL_W'(1);
                        end
                    end
                end
                StOpen: begin
                    if (enter_btn) begin
                        state  <= StIdle;
                        unlock <= 1'b0;
                    end else if (change_btn) begin
                        state  <= StChange;
                        unlock <= 1'b0;
                    end else if (anyStrobe) begin
                        openTimer <= '0;
                    end else if (openTimer == OpenLast) begin
                        state  <= StIdle;
                        unlock <= 1'b0;
                    end else begin
                        openTimer <= openTimer + TimerW'(1);
                    end
                end
                StChange: begin
                    if (enter_btn) begin
                        state     <= StOpen;
                        unlock    <= 1'b1;
                        openTimer <= '0;
                    end else if (done) begin
                        state   <= StReenter;
                        newCode <= digits;
                    end
                end
                StReenter: begin
                    if (enter_btn || done) begin
                        if (!enter_btn && (digits == newCode)) begin
                            storedCode <= digits;
                        end
                        state     <= StOpen;
                        unlock    <= 1'b1;
                        openTimer <= '0;
                    end
                end
                StScroll: begin
                    if (finished_scrolling) begin
`ifdef LOCK_LOCKOUT_EN
                        state     <= StClosed;
                        lockTimer <= '0;
`else
                        state     <= StIdle;
`endif
                    end
                end
                StClosed: begin
`ifdef LOCK_LOCKOUT_EN
                    if (lockTimer == LockLast) begin
                        state <= StIdle;
                    end else begin
                        lockTimer <= lockTimer + TimerW'(1);
                    end
`else
                    state <= StIdle;
`endif
                end
                default: begin
                    state  <= StIdle;
                    unlock <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed and randomized bench for lock_sequencer against a code/fail-count reference model.
module tb_lock_sequencer;

    localparam int unsigned OT = 20;
    localparam int unsigned LT = 30;
    localparam int unsigned MF = 3;
    localparam logic [15:0] DEF = 16'h1234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        enter_btn = 1'b0;
    logic        change_btn = 1'b0;
    logic        finished_scrolling = 1'b0;
    logic [2:0]  gate_status;
    logic [1:0]  current_index;
    logic [15:0] display_elements;
    logic        unlock;

    int checks = 0;
    int failures = 0;

    // Reference model: stored code and consecutive-failure count.
    logic [15:0] mCode = DEF;
    int          mFails = 0;

    always #5 clk = ~clk;

    lock_sequencer #(
        .DEFAULT_CODE  (DEF),
        .MAX_FAILS     (MF),
        .OPEN_TICKS    (OT),
        .LOCKOUT_TICKS (LT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .digit_valid        (digit_valid),
        .digit              (digit),
        .enter_btn          (enter_btn),
        .change_btn         (change_btn),
        .finished_scrolling (finished_scrolling),
        .gate_status        (gate_status),
        .current_index      (current_index),
        .display_elements   (display_elements),
        .unlock             (unlock)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic checkOut(input string tag, input logic [2:0] gs, input logic [1:0] idx,
                            input logic [15:0] disp);
        check({tag, ".gate_status"}, 16'(gate_status), 16'(gs));
        check({tag, ".unlock"}, 16'(unlock), 16'(gs == 3'd1));
        check({tag, ".current_index"}, 16'(current_index), 16'(idx));
        check({tag, ".display"}, display_elements, disp);
    endtask

    function automatic logic [3:0] digitOf(input logic [15:0] c, input int i);
        return 4'((c >> (12 - 4 * i)) & 16'hF);
    endfunction

    function automatic logic [15:0] prefix(input logic [15:0] c, input int n);
        return c & ~(16'hFFFF >> (4 * n));
    endfunction

    function automatic logic [15:0] randCode();
        logic [15:0] c = 16'h0;
        for (int i = 0; i < 4; i++) c = (c << 4) | 16'($urandom_range(0, 9));
        return c;
    endfunction

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1;
        digit = d;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic pulseEnter();
        enter_btn = 1'b1;
        tick();
        enter_btn = 1'b0;
    endtask

    task automatic pulseChange();
        change_btn = 1'b1;
        tick();
        change_btn = 1'b0;
    endtask

    task automatic pulseScroll();
        finished_scrolling = 1'b1;
        tick();
        finished_scrolling = 1'b0;
    endtask

    task automatic typeDigits(input string tag, input logic [15:0] c, input logic [2:0] gs);
        for (int i = 0; i < 4; i++) begin
            press(digitOf(c, i));
            checkOut(tag, gs, 2'(i), prefix(c, i + 1));
        end
    endtask

    // One full entry from IDLE; the outcome follows the match / fail-count rules.
    task automatic attempt(input string tag, input logic [15:0] c, output logic [2:0] res);
        typeDigits(tag, c, 3'd3);
        tick();
        if (c == mCode) begin
            res = 3'd1;
            mFails = 0;
        end else if (mFails + 1 >= int'(MF)) begin
            res = 3'd6;
            mFails = 0;
        end else begin
            res = 3'd2;
            mFails++;
        end
        checkOut({tag, ".result"}, res, 2'd0, 16'h0);
    endtask

    task automatic lockoutRecover(input string tag);
        press(4'd3);
        checkOut({tag, ".scroll_ignores_digit"}, 3'd6, 2'd0, 16'h0);
        pulseScroll();
`ifdef LOCK_LOCKOUT_EN
        checkOut({tag, ".closed"}, 3'd0, 2'd0, 16'h0);
        pulseScroll();
        press(4'd7);
        checkOut({tag, ".closed_ignores"}, 3'd0, 2'd0, 16'h0);
        repeat (LT - 3) tick();
        checkOut({tag, ".closed_last"}, 3'd0, 2'd0, 16'h0);
        tick();
        checkOut({tag, ".closed_exit"}, 3'd2, 2'd0, 16'h0);
`else
        checkOut({tag, ".scroll_to_idle"}, 3'd2, 2'd0, 16'h0);
`endif
    endtask

    initial begin
        logic [2:0]  res;
        logic [15:0] c;
        logic [15:0] c2;

        tick();
        checkOut("reset_held", 3'd2, 2'd0, 16'h0);
        rst_n = 1'b1;
        tick();
        checkOut("reset_released", 3'd2, 2'd0, 16'h0);

        pulseChange();
        pulseEnter();
        press(4'hA);
        checkOut("idle_ignores", 3'd2, 2'd0, 16'h0);

        // Correct code then open timeout.
        attempt("correct", DEF, res);
        repeat (OT - 1) tick();
        checkOut("open_last", 3'd1, 2'd0, 16'h0);
        tick();
        checkOut("open_timeout", 3'd2, 2'd0, 16'h0);

        // Three wrong entries trigger lockout.
        for (int k = 0; k < 3; k++) attempt("wrong", 16'h5555, res);
        lockoutRecover("lockout");

        // Randomized attempts.
        for (int k = 0; k < 8; k++) begin
            c = ($urandom_range(0, 2) == 0) ? mCode : randCode();
            attempt("rand", c, res);
            if (res == 3'd1) begin
                pulseEnter();
                checkOut("rand.lock", 3'd2, 2'd0, 16'h0);
            end else if (res == 3'd6) begin
                lockoutRecover("rand_lockout");
            end
        end

        // Strobe in OPEN restarts the timer.
        attempt("restart", mCode, res);
        repeat (15) tick();
        press(4'd2);
        checkOut("open_digit", 3'd1, 2'd0, 16'h0);
        repeat (OT - 1) tick();
        checkOut("restart_last", 3'd1, 2'd0, 16'h0);
        tick();
        checkOut("restart_timeout", 3'd2, 2'd0, 16'h0);

        // Mismatched re-entry leaves the code alone.
        attempt("mm_open", mCode, res);
        pulseChange();
        checkOut("mm_change", 3'd4, 2'd0, 16'h0);
        c = randCode();
        c2 = {c[15:4], 4'((c[3:0] + 4'd1) % 4'd10)};
        typeDigits("mm_new", c, 3'd4);
        tick();
        checkOut("mm_reenter", 3'd5, 2'd0, 16'h0);
        typeDigits("mm_again", c2, 3'd5);
        tick();
        checkOut("mm_back_open", 3'd1, 2'd0, 16'h0);
        pulseEnter();
        if (c != mCode) attempt("mm_new_rejected", c, res);
        attempt("mm_old_ok", mCode, res);
        pulseEnter();

        // Abort during CHANGE returns to OPEN.
        attempt("abort_open", mCode, res);
        pulseChange();
        press(4'd4);
        press(4'd5);
        pulseEnter();
        checkOut("abort_change", 3'd1, 2'd0, 16'h0);
        pulseEnter();

        // Successful code change to 9876.
        attempt("chg_open", mCode, res);
        pulseChange();
        typeDigits("chg_new", 16'h9876, 3'd4);
        tick();
        checkOut("chg_reenter", 3'd5, 2'd0, 16'h0);
        typeDigits("chg_again", 16'h9876, 3'd5);
        tick();
        checkOut("chg_done", 3'd1, 2'd0, 16'h0);
        mCode = 16'h9876;
        pulseEnter();
        checkOut("chg_lock", 3'd2, 2'd0, 16'h0);
        attempt("chg_old_rejected", DEF, res);
        attempt("chg_new_ok", 16'h9876, res);
        pulseEnter();

        // enter_btn with digit_valid mid-ENTER aborts.
        press(4'd1);
        press(4'd2);
        digit_valid = 1'b1;
        digit = 4'd3;
        enter_btn = 1'b1;
        tick();
        digit_valid = 1'b0;
        enter_btn = 1'b0;
        checkOut("abort_enter", 3'd2, 2'd0, 16'h0);

        // Non-BCD digit ignored mid-entry; digit on the compare cycle dropped.
        press(digitOf(mCode, 0));
        press(4'hA);
        checkOut("digit_a", 3'd3, 2'd0, prefix(mCode, 1));
        for (int i = 1; i < 4; i++) press(digitOf(mCode, i));
        checkOut("full_entry", 3'd3, 2'd3, mCode);
        press(4'd5);
        checkOut("compare_drop", 3'd1, 2'd0, 16'h0);
        mFails = 0;
        pulseEnter();

        // Reset in REENTER restores the default code.
        attempt("rst_open", mCode, res);
        pulseChange();
        typeDigits("rst_new", 16'h4321, 3'd4);
        tick();
        press(4'd4);
        press(4'd3);
        checkOut("rst_mid", 3'd5, 2'd1, 16'h4300);
        rst_n = 1'b0;
        #1;
        checkOut("rst_async", 3'd2, 2'd0, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        c = mCode;
        mCode = DEF;
        mFails = 0;
        attempt("rst_old_rejected", c, res);
        attempt("rst_default_ok", DEF, res);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
